// File: rtl/calc_pkg.sv
// Shared types and widths for the two-requester calculator arbiter.
package calc_pkg;

  localparam int unsigned OPW  = 4;
  localparam int unsigned RESW = 8;
  localparam int unsigned NREQ = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    RESP = 2'b11
  } state_e;

endpackage

// File: rtl/calc_arbiter_if.sv
// Request/response handshake bundle between the input decoders, the arbiter and the output stage.
interface calc_arbiter_if;
  import calc_pkg::*;

  logic            req0_valid;
  op_e             req0_op;
  logic [OPW-1:0]  req0_a;
  logic [OPW-1:0]  req0_b;
  logic            req0_ready;

  logic            req1_valid;
  op_e             req1_op;
  logic [OPW-1:0]  req1_a;
  logic [OPW-1:0]  req1_b;
  logic            req1_ready;

  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [RESW-1:0] rsp_data;
  logic            rsp_err;

  // Requester/consumer side.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/calc_alu.sv
// Combinational single-cycle ALU: ADD, SUB (mod 256) and AND on 4-bit operands.
module calc_alu
  import calc_pkg::*;
(
  input  op_e             op,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic [RESW-1:0] res
);

  always_comb begin
    res = '0;
    unique case (op)
      OP_ADD:  res = {3'b000, {1'b0, a} + {1'b0, b}};
      OP_SUB:  res = {4'b0000, a} - {4'b0000, b};
      OP_AND:  res = {4'b0000, a & b};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin arbiter and op sequencer sharing one calculator datapath between two requesters.
// Define CALC_MUL_EN to build the shift-add multiplier; otherwise opcode 11 returns rsp_err.
module calc_arbiter
  import calc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  calc_arbiter_if.slave bus
);

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            id_q, id_d;
  op_e             op_q, op_d;
  logic [OPW-1:0]  a_q, a_d;
  logic [OPW-1:0]  b_q, b_d;
  logic [RESW-1:0] data_q, data_d;
  logic            err_q, err_d;

  logic            gnt_vld;
  logic            gnt_id;
  logic            idle;
  logic            accept;
  op_e             op_in;
  logic [RESW-1:0] alu_res;

`ifdef CALC_MUL_EN
  logic [1:0]      cnt_q, cnt_d;
  logic [RESW-1:0] acc_q, acc_d;
  logic [RESW-1:0] acc_next;
`endif

  // On a tie the requester that was not granted last wins.
  always_comb begin
    gnt_vld = bus.req0_valid | bus.req1_valid;
    gnt_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_q;
    end else if (bus.req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign idle           = (state_q == IDLE);
  assign accept         = idle & gnt_vld;
  assign bus.req0_ready = accept & ~gnt_id;
  assign bus.req1_ready = accept & gnt_id;
  assign op_in          = gnt_id ? bus.req1_op : bus.req0_op;

  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_err    = err_q;

  calc_alu u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (alu_res)
  );

`ifdef CALC_MUL_EN
  assign acc_next = acc_q + (b_q[cnt_q] ? ({4'b0000, a_q} << cnt_q) : '0);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef CALC_MUL_EN
    cnt_d   = cnt_q;
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_d  = gnt_id;
          id_d    = gnt_id;
          op_d    = op_in;
          a_d     = gnt_id ? bus.req1_a : bus.req0_a;
          b_d     = gnt_id ? bus.req1_b : bus.req0_b;
          state_d = EXEC;
`ifdef CALC_MUL_EN
          if (op_in == OP_MUL) begin
            state_d = MUL;
            cnt_d   = '0;
            acc_d   = '0;
          end
`endif
        end
      end
      EXEC: begin
        // Only an unsupported multiply can reach EXEC with OP_MUL.
        err_d   = (op_q == OP_MUL);
        data_d  = (op_q == OP_MUL) ? '0 : alu_res;
        state_d = RESP;
      end
`ifdef CALC_MUL_EN
      MUL: begin
        acc_d = acc_next;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          data_d  = acc_next;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
`endif
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef CALC_MUL_EN
      cnt_q   <= '0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef CALC_MUL_EN
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
`endif
    end
  end

endmodule
